// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: captures the decode control word, operands and register fields.
// Supports stall (hold), flush (bubble), a valid bit and a saturating flush counter.
module id_ex_pipe_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall_E,
    input  logic                 flush_E,
    input  logic                 valid_D,
    input  logic                 MemToReg_D,
    input  logic                 MemWrite_D,
    input  logic                 ALUSrc_D,
    input  logic                 RegDest_D,
    input  logic                 RegWrite_D,
    input  logic                 JAL_D,
    input  logic                 JR_D,
    input  logic                 shift_D,
    input  logic                 Branch_eq_D,
    input  logic                 Branch_ne_D,
    input  logic [2:0]           ALUControl_D,
    input  logic [WIDTH-1:0]     RD1_D,
    input  logic [WIDTH-1:0]     RD2_D,
    input  logic [WIDTH-1:0]     SignImm_D,
    input  logic [WIDTH-1:0]     PCPlus4_D,
    input  logic [4:0]           Rs_D,
    input  logic [4:0]           Rt_D,
    input  logic [4:0]           Rd_D,
    input  logic [4:0]           Shamt_D,
    output logic                 valid_E,
    output logic                 MemToReg_E,
    output logic                 MemWrite_E,
    output logic                 ALUSrc_E,
    output logic                 RegDest_E,
    output logic                 RegWrite_E,
    output logic                 JAL_E,
    output logic                 JR_E,
    output logic                 shift_E,
    output logic                 Branch_eq_E,
    output logic                 Branch_ne_E,
    output logic [2:0]           ALUControl_E,
    output logic [WIDTH-1:0]     RD1_E,
    output logic [WIDTH-1:0]     RD2_E,
    output logic [WIDTH-1:0]     SignImm_E,
    output logic [WIDTH-1:0]     PCPlus4_E,
    output logic [4:0]           Rs_E,
    output logic [4:0]           Rt_E,
    output logic [4:0]           Rd_E,
    output logic [4:0]           Shamt_E,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);

    localparam int unsigned CtrlW = 13;

    logic [CtrlW-1:0] ctrl_d;
    logic [CtrlW-1:0] ctrl_q;

    assign ctrl_d = {MemToReg_D, MemWrite_D, ALUSrc_D, RegDest_D, RegWrite_D, JAL_D, JR_D,
                     shift_D, Branch_eq_D, Branch_ne_D, ALUControl_D};

    assign {MemToReg_E, MemWrite_E, ALUSrc_E, RegDest_E, RegWrite_E, JAL_E, JR_E,
            shift_E, Branch_eq_E, Branch_ne_E, ALUControl_E} = ctrl_q;

    always_ff @(posedge clk) begin
        if (!reset_n || flush_E) begin
            ctrl_q    <= '0;
            valid_E   <= 1'b0;
            RD1_E     <= '0;
            RD2_E     <= '0;
            SignImm_E <= '0;
            PCPlus4_E <= '0;
            Rs_E      <= '0;
            Rt_E      <= '0;
            Rd_E      <= '0;
            Shamt_E   <= '0;
        end else if (!stall_E) begin
            // An invalid decode slot must never carry live control into EX.
            ctrl_q    <= valid_D ? ctrl_d : '0;
            valid_E   <= valid_D;
            RD1_E     <= RD1_D;
            RD2_E     <= RD2_D;
            SignImm_E <= SignImm_D;
            PCPlus4_E <= PCPlus4_D;
            Rs_E      <= Rs_D;
            Rt_E      <= Rt_D;
            Rd_E      <= Rd_D;
            Shamt_E   <= Shamt_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
        end else if (flush_E && (bubble_cnt != {CNT_WIDTH{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed steps then random traffic against a
// stage-level reference model; a second instance with a 2-bit counter covers saturation.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        mem_to_reg, mem_write, alu_src, reg_dest, reg_write;
        logic        jal, jr, shift, branch_eq, branch_ne;
        logic [2:0]  alu_control;
        logic [31:0] rd1, rd2, sign_imm, pc_plus4;
        logic [4:0]  rs, rt, rd, shamt;
    } stage_t;

    logic   clk;
    logic   reset_n, stall_E, flush_E;
    stage_t din;
    stage_t obs, obs2, exp_s;
    int     cnt16, cnt2;
    int     checks, errors;

    logic        valid_E, MemToReg_E, MemWrite_E, ALUSrc_E, RegDest_E, RegWrite_E;
    logic        JAL_E, JR_E, shift_E, Branch_eq_E, Branch_ne_E;
    logic [2:0]  ALUControl_E;
    logic [31:0] RD1_E, RD2_E, SignImm_E, PCPlus4_E;
    logic [4:0]  Rs_E, Rt_E, Rd_E, Shamt_E;
    logic [15:0] bubble_cnt;

    logic        valid_E2, MemToReg_E2, MemWrite_E2, ALUSrc_E2, RegDest_E2, RegWrite_E2;
    logic        JAL_E2, JR_E2, shift_E2, Branch_eq_E2, Branch_ne_E2;
    logic [2:0]  ALUControl_E2;
    logic [31:0] RD1_E2, RD2_E2, SignImm_E2, PCPlus4_E2;
    logic [4:0]  Rs_E2, Rt_E2, Rd_E2, Shamt_E2;
    logic [1:0]  bubble_cnt2;

    id_ex_pipe_reg dut (
        .clk(clk), .reset_n(reset_n), .stall_E(stall_E), .flush_E(flush_E),
        .valid_D(din.valid), .MemToReg_D(din.mem_to_reg), .MemWrite_D(din.mem_write),
        .ALUSrc_D(din.alu_src), .RegDest_D(din.reg_dest), .RegWrite_D(din.reg_write),
        .JAL_D(din.jal), .JR_D(din.jr), .shift_D(din.shift), .Branch_eq_D(din.branch_eq),
        .Branch_ne_D(din.branch_ne), .ALUControl_D(din.alu_control), .RD1_D(din.rd1),
        .RD2_D(din.rd2), .SignImm_D(din.sign_imm), .PCPlus4_D(din.pc_plus4),
        .Rs_D(din.rs), .Rt_D(din.rt), .Rd_D(din.rd), .Shamt_D(din.shamt),
        .valid_E(valid_E), .MemToReg_E(MemToReg_E), .MemWrite_E(MemWrite_E),
        .ALUSrc_E(ALUSrc_E), .RegDest_E(RegDest_E), .RegWrite_E(RegWrite_E), .JAL_E(JAL_E),
        .JR_E(JR_E), .shift_E(shift_E), .Branch_eq_E(Branch_eq_E),
        .Branch_ne_E(Branch_ne_E), .ALUControl_E(ALUControl_E), .RD1_E(RD1_E),
        .RD2_E(RD2_E), .SignImm_E(SignImm_E), .PCPlus4_E(PCPlus4_E), .Rs_E(Rs_E),
        .Rt_E(Rt_E), .Rd_E(Rd_E), .Shamt_E(Shamt_E), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe_reg #(.WIDTH(32), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .stall_E(stall_E), .flush_E(flush_E),
        .valid_D(din.valid), .MemToReg_D(din.mem_to_reg), .MemWrite_D(din.mem_write),
        .ALUSrc_D(din.alu_src), .RegDest_D(din.reg_dest), .RegWrite_D(din.reg_write),
        .JAL_D(din.jal), .JR_D(din.jr), .shift_D(din.shift), .Branch_eq_D(din.branch_eq),
        .Branch_ne_D(din.branch_ne), .ALUControl_D(din.alu_control), .RD1_D(din.rd1),
        .RD2_D(din.rd2), .SignImm_D(din.sign_imm), .PCPlus4_D(din.pc_plus4),
        .Rs_D(din.rs), .Rt_D(din.rt), .Rd_D(din.rd), .Shamt_D(din.shamt),
        .valid_E(valid_E2), .MemToReg_E(MemToReg_E2), .MemWrite_E(MemWrite_E2),
        .ALUSrc_E(ALUSrc_E2), .RegDest_E(RegDest_E2), .RegWrite_E(RegWrite_E2),
        .JAL_E(JAL_E2), .JR_E(JR_E2), .shift_E(shift_E2), .Branch_eq_E(Branch_eq_E2),
        .Branch_ne_E(Branch_ne_E2), .ALUControl_E(ALUControl_E2), .RD1_E(RD1_E2),
        .RD2_E(RD2_E2), .SignImm_E(SignImm_E2), .PCPlus4_E(PCPlus4_E2), .Rs_E(Rs_E2),
        .Rt_E(Rt_E2), .Rd_E(Rd_E2), .Shamt_E(Shamt_E2), .bubble_cnt(bubble_cnt2)
    );

    assign obs = {valid_E, MemToReg_E, MemWrite_E, ALUSrc_E, RegDest_E, RegWrite_E, JAL_E,
                  JR_E, shift_E, Branch_eq_E, Branch_ne_E, ALUControl_E, RD1_E, RD2_E,
                  SignImm_E, PCPlus4_E, Rs_E, Rt_E, Rd_E, Shamt_E};
    assign obs2 = {valid_E2, MemToReg_E2, MemWrite_E2, ALUSrc_E2, RegDest_E2, RegWrite_E2,
                   JAL_E2, JR_E2, shift_E2, Branch_eq_E2, Branch_ne_E2, ALUControl_E2,
                   RD1_E2, RD2_E2, SignImm_E2, PCPlus4_E2, Rs_E2, Rt_E2, Rd_E2, Shamt_E2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: what the EX stage should hold after one edge.
    function automatic stage_t model_next(stage_t cur, stage_t d, bit rst_n, bit stall,
                                          bit flush);
        stage_t r;
        if (!rst_n || flush) return '0;
        if (stall) return cur;
        r = d;
        if (!d.valid) begin
            {r.mem_to_reg, r.mem_write, r.alu_src, r.reg_dest, r.reg_write} = '0;
            {r.jal, r.jr, r.shift, r.branch_eq, r.branch_ne} = '0;
            r.alu_control = 3'b000;
        end
        return r;
    endfunction

    function automatic int count_next(int c, bit rst_n, bit flush, int max);
        if (!rst_n) return 0;
        if (flush && c < max) return c + 1;
        return c;
    endfunction

    function automatic stage_t rand_stage();
        logic [191:0] bits;
        bits = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return bits[$bits(stage_t)-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_model(input string tag);
        checks++;
        assert (obs === exp_s) else begin
            errors++;
            $error("FAIL %s/stage: observed %h expected %h", tag, obs, exp_s);
        end
        checks++;
        assert (obs2 === exp_s) else begin
            errors++;
            $error("FAIL %s/stage2: observed %h expected %h", tag, obs2, exp_s);
        end
        chk({tag, "/cnt16"}, 64'(bubble_cnt), 64'(cnt16));
        chk({tag, "/cnt2"}, 64'(bubble_cnt2), 64'(cnt2));
    endtask

    task automatic step(input stage_t d, input bit rst_n, input bit stall, input bit flush,
                        input string tag);
        din     = d;
        reset_n = rst_n;
        stall_E = stall;
        flush_E = flush;
        @(posedge clk);
        exp_s = model_next(exp_s, d, rst_n, stall, flush);
        cnt16 = count_next(cnt16, rst_n, flush, 65535);
        cnt2  = count_next(cnt2, rst_n, flush, 3);
        #1;
        check_model(tag);
    endtask

    initial begin
        stage_t d;
        int     sat_exp[5];
        checks  = 0;
        errors  = 0;
        exp_s   = '0;
        cnt16   = 0;
        cnt2    = 0;
        reset_n = 1'b0;
        stall_E = 1'b0;
        flush_E = 1'b0;
        din     = '0;
        #2;

        // Reset with every decode field nonzero.
        d = '1;
        step(d, 1'b0, 1'b0, 1'b0, "reset");
        chk("reset/valid_E", 64'(valid_E), 64'd0);
        chk("reset/RD1_E", 64'(RD1_E), 64'd0);

        // Pass-through.
        d = '0;
        d.valid = 1'b1;
        d.rd1 = 32'h1234_5678;
        d.reg_write = 1'b1;
        d.alu_control = 3'b010;
        step(d, 1'b1, 1'b0, 1'b0, "pass");
        chk("pass/RD1_E", 64'(RD1_E), 64'h1234_5678);
        chk("pass/RegWrite_E", 64'(RegWrite_E), 64'd1);
        chk("pass/ALUControl_E", 64'(ALUControl_E), 64'd2);
        chk("pass/valid_E", 64'(valid_E), 64'd1);

        // Stall holds for three edges, releases on the fourth.
        d.rd2 = 32'hA;
        step(d, 1'b1, 1'b0, 1'b0, "stall_load");
        d.rd2 = 32'hB;
        for (int i = 0; i < 3; i++) begin
            step(d, 1'b1, 1'b1, 1'b0, "stall_hold");
            chk("stall/RD2_E_held", 64'(RD2_E), 64'hA);
        end
        step(d, 1'b1, 1'b0, 1'b0, "stall_release");
        chk("stall/RD2_E_new", 64'(RD2_E), 64'hB);

        // Flush wins over stall on the same edge.
        d = '0;
        d.valid = 1'b1;
        d.mem_write = 1'b1;
        step(d, 1'b1, 1'b0, 1'b0, "fs_load");
        chk("fs/MemWrite_E_loaded", 64'(MemWrite_E), 64'd1);
        step(d, 1'b1, 1'b1, 1'b1, "flush_stall");
        chk("fs/MemWrite_E", 64'(MemWrite_E), 64'd0);
        chk("fs/valid_E", 64'(valid_E), 64'd0);
        chk("fs/bubble_cnt", 64'(bubble_cnt), 64'd1);

        // Invalid decode slot: control squashed, fields captured.
        d = '0;
        d.reg_write = 1'b1;
        d.branch_eq = 1'b1;
        d.rs = 5'd7;
        step(d, 1'b1, 1'b0, 1'b0, "invalid");
        chk("invalid/RegWrite_E", 64'(RegWrite_E), 64'd0);
        chk("invalid/Branch_eq_E", 64'(Branch_eq_E), 64'd0);
        chk("invalid/Rs_E", 64'(Rs_E), 64'd7);
        chk("invalid/valid_E", 64'(valid_E), 64'd0);

        // 2-bit counter saturation after a fresh reset.
        step(rand_stage(), 1'b0, 1'b0, 1'b1, "sat_reset");
        sat_exp = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            step(rand_stage(), 1'b1, 1'b0, 1'b1, "sat");
            chk("sat/bubble_cnt2", 64'(bubble_cnt2), 64'(sat_exp[i]));
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(rand_stage(), ($urandom_range(0, 29) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
